// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width and the ALU operation encoding.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/forward_mux.sv
// Per-source operand forwarding: the younger EX/MEM result wins over MEM/WB,
// and a load in EX/MEM is never forwarded because its data does not exist yet.
module forward_mux #(
    parameter int XLEN = riscv_pkg::XLEN_DEFAULT
) (
    input  logic [4:0]      i_src_addr,
    input  logic [XLEN-1:0] i_reg_data,
    input  logic [4:0]      i_exmem_rd,
    input  logic            i_exmem_reg_write,
    input  logic            i_exmem_is_load,
    input  logic [XLEN-1:0] i_exmem_result,
    input  logic [4:0]      i_memwb_rd,
    input  logic            i_memwb_reg_write,
    input  logic [XLEN-1:0] i_memwb_result,
    output logic [XLEN-1:0] o_data
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    // x0 never matches because both hit terms require a nonzero destination.
    assign w_exmem_hit = i_exmem_reg_write && !i_exmem_is_load &&
                         (i_exmem_rd != 5'd0) && (i_exmem_rd == i_src_addr);
    assign w_memwb_hit = i_memwb_reg_write &&
                         (i_memwb_rd != 5'd0) && (i_memwb_rd == i_src_addr);

    // Priority select of the freshest available value.
    always_comb begin
        o_data = i_reg_data;
        if (w_exmem_hit) begin
            o_data = i_exmem_result;
        end else if (w_memwb_hit) begin
            o_data = i_memwb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// Single-entry operand stage in front of the ALU: holds one decoded
// instruction, resolves forwarding from held state, stalls on load-use.
module ex_operand_stage #(
    parameter int XLEN = riscv_pkg::XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [3:0]      alu_op,
    input  logic            use_imm,
    input  logic            is_word,
    input  logic            reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic            exmem_is_load,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [5:0]      shamt,
    output logic [3:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_is_word,
    output logic [15:0]     stall_count
);

    import riscv_pkg::*;

    logic            r_valid;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd_addr;
    alu_op_e         r_alu_op;
    logic            r_use_imm;
    logic            r_is_word;
    logic            r_reg_write;
    logic [15:0]     r_stall_count;

    logic            w_hazard;
    logic            w_out_valid;
    logic            w_in_ready;
    logic            w_capture;
    logic            w_drain;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_op_b;

    // Load-use: the load result is not ready yet, so the held entry must wait.
    // rs2 only matters when the immediate is not replacing it.
    assign w_hazard = r_valid && exmem_is_load && exmem_reg_write &&
                      (exmem_rd != 5'd0) &&
                      ((exmem_rd == r_rs1_addr) ||
                       ((exmem_rd == r_rs2_addr) && !r_use_imm));

    assign w_out_valid = r_valid && !w_hazard;
    assign w_drain     = w_out_valid && out_ready;
    assign w_in_ready  = !r_valid || w_drain;
    assign w_capture   = in_valid && w_in_ready;

    forward_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .i_src_addr        (r_rs1_addr),
        .i_reg_data        (r_rs1_data),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_is_load   (exmem_is_load),
        .i_exmem_result    (exmem_result),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rs1)
    );

    forward_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .i_src_addr        (r_rs2_addr),
        .i_reg_data        (r_rs2_data),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_is_load   (exmem_is_load),
        .i_exmem_result    (exmem_result),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rs2)
    );

    assign w_op_b = r_use_imm ? r_imm : w_fwd_rs2;

    // Entry register: flush wins over capture; capture may coincide with drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_alu_op    <= ALU_ADD;
            r_use_imm   <= 1'b0;
            r_is_word   <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_rs1_data  <= rs1_data;
            r_rs2_data  <= rs2_data;
            r_imm       <= imm;
            r_rs1_addr  <= rs1_addr;
            r_rs2_addr  <= rs2_addr;
            r_rd_addr   <= rd_addr;
            r_alu_op    <= alu_op_e'(alu_op);
            r_use_imm   <= use_imm;
            r_is_word   <= is_word;
            r_reg_write <= reg_write;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_hazard && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign op_a          = w_fwd_rs1;
    assign op_b          = w_op_b;
    // W-ops shift by at most 31, so bit 5 of the amount is ignored.
    assign shamt         = r_is_word ? {1'b0, w_op_b[4:0]} : w_op_b[5:0];
    assign out_alu_op    = r_alu_op;
    assign out_rd        = r_rd_addr;
    assign out_reg_write = r_reg_write && w_out_valid;
    assign out_is_word   = r_is_word;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [3:0]      alu_op;
    logic            use_imm;
    logic            is_word;
    logic            reg_write;
    logic [4:0]      exmem_rd;
    logic            exmem_reg_write;
    logic            exmem_is_load;
    logic [XLEN-1:0] exmem_result;
    logic [4:0]      memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_result;
    logic            flush;
    logic            out_ready;
    logic            out_valid;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [5:0]      shamt;
    logic [3:0]      out_alu_op;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            out_is_word;
    logic [15:0]     stall_count;

    int n_checks;
    int n_errors;

    ex_operand_stage #(.XLEN(XLEN)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .imm             (imm),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rd_addr         (rd_addr),
        .alu_op          (alu_op),
        .use_imm         (use_imm),
        .is_word         (is_word),
        .reg_write       (reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_is_load   (exmem_is_load),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .flush           (flush),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .op_a            (op_a),
        .op_b            (op_b),
        .shamt           (shamt),
        .out_alu_op      (out_alu_op),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write),
        .out_is_word     (out_is_word),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one instruction for a single edge.
    task automatic push();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_fwd();
        exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_is_load = 1'b0; exmem_result = '0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; rs1_data = '0; rs2_data = '0; imm = '0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; alu_op = '0;
        use_imm = 1'b0; is_word = 1'b0; reg_write = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        clear_fwd();

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall", 64'(stall_count), 64'd0);
        check("rst_op_a", op_a, 64'd0);
        check("rst_op_b", op_b, 64'd0);
        check("rst_reg_write", 64'(out_reg_write), 64'd0);
        #10;
        rst_n = 1'b1;

        // Basic capture and pass-through
        out_ready = 1'b1;
        rs1_addr = 5'd1; rs1_data = 64'd5; rs2_addr = 5'd2; rs2_data = 64'd7;
        rd_addr = 5'd5; alu_op = 4'd0; reg_write = 1'b1;
        push();
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_op_a", op_a, 64'd5);
        check("basic_op_b", op_b, 64'd7);
        check("basic_in_ready", 64'(in_ready), 64'd1);
        check("basic_rd", 64'(out_rd), 64'd5);
        check("basic_reg_write", 64'(out_reg_write), 64'd1);
        @(posedge clk); #1;
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_reg_write", 64'(out_reg_write), 64'd0);

        // Forwarding priority on rs1
        out_ready = 1'b0;
        rs1_addr = 5'd3; rs1_data = 64'h11; rs2_addr = 5'd0; rs2_data = 64'h22;
        rd_addr = 5'd7; alu_op = 4'd1;
        push();
        check("fwd_none", op_a, 64'h11);
        check("fwd_alu_op", 64'(out_alu_op), 64'd1);
        exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 64'hAA;
        memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 64'hBB;
        #1; check("fwd_exmem", op_a, 64'hAA);
        exmem_reg_write = 1'b0;
        #1; check("fwd_memwb", op_a, 64'hBB);
        memwb_reg_write = 1'b0;
        #1; check("fwd_reg", op_a, 64'h11);

        // Drain and capture on the same edge; x0 source is never forwarded
        rs1_addr = 5'd0; rs1_data = 64'h33; rs2_addr = 5'd3; rs2_data = 64'h44;
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 64'hAA;
        memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 64'hBB;
        out_ready = 1'b1;
        push();
        out_ready = 1'b0;
        check("nobubble_valid", 64'(out_valid), 64'd1);
        check("x0_op_a", op_a, 64'h33);
        check("fwd_rs2_memwb", op_b, 64'hBB);
        exmem_rd = 5'd3;
        #1; check("fwd_rs2_exmem", op_b, 64'hAA);
        memwb_rd = 5'd0; exmem_rd = 5'd0;
        #1; check("x0_op_a_exmem0", op_a, 64'h33);
        clear_fwd();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain2_valid", 64'(out_valid), 64'd0);

        // Load-use hazard on rs2
        rs1_addr = 5'd1; rs1_data = 64'h10; rs2_addr = 5'd4; rs2_data = 64'h44;
        use_imm = 1'b0;
        push();
        exmem_rd = 5'd4; exmem_reg_write = 1'b1; exmem_is_load = 1'b1;
        #1;
        check("haz_valid0", 64'(out_valid), 64'd0);
        check("haz_in_ready", 64'(in_ready), 64'd0);
        check("haz_reg_write", 64'(out_reg_write), 64'd0);
        @(posedge clk); #1;
        check("haz_valid1", 64'(out_valid), 64'd0);
        check("haz_stall1", 64'(stall_count), 64'd1);
        @(posedge clk); #1;
        clear_fwd();
        #1;
        check("haz_stall2", 64'(stall_count), 64'd2);
        check("haz_release_valid", 64'(out_valid), 64'd1);
        check("haz_release_op_b", op_b, 64'h44);
        check("haz_release_op_a", op_a, 64'h10);
        @(posedge clk); #1;
        check("haz_drained", 64'(out_valid), 64'd0);

        // Load in EX/MEM matching rs2 is harmless when the immediate is used
        out_ready = 1'b0;
        use_imm = 1'b1; imm = 64'h9;
        push();
        exmem_rd = 5'd4; exmem_reg_write = 1'b1; exmem_is_load = 1'b1;
        @(posedge clk); #1;
        check("imm_nohaz_valid", 64'(out_valid), 64'd1);
        check("imm_nohaz_op_b", op_b, 64'h9);
        check("imm_nohaz_stall", 64'(stall_count), 64'd2);
        clear_fwd();

        // Shift amount formation
        use_imm = 1'b0; rs2_addr = 5'd6; rs2_data = 64'h3F; is_word = 1'b1;
        out_ready = 1'b1;
        push();
        out_ready = 1'b0;
        check("shamt_word", 64'(shamt), 64'h1F);
        check("is_word_out", 64'(out_is_word), 64'd1);
        is_word = 1'b0;
        out_ready = 1'b1;
        push();
        out_ready = 1'b0;
        check("shamt_dword", 64'(shamt), 64'h3F);
        use_imm = 1'b1; imm = 64'h25;
        out_ready = 1'b1;
        push();
        out_ready = 1'b0;
        check("shamt_imm", 64'(shamt), 64'h25);
        check("op_b_imm", op_b, 64'h25);

        // Flush overrides a simultaneous capture
        flush = 1'b1; in_valid = 1'b1; rs1_data = 64'h77;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_reg_write", 64'(out_reg_write), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back stream
        use_imm = 1'b0; rs1_addr = 5'd1; out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            rs1_data = 64'(k);
            @(posedge clk); #1;
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_op_a", op_a, 64'(k));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_end", 64'(out_valid), 64'd0);

        // Reset asserted mid-hold
        out_ready = 1'b0; rs1_data = 64'h55;
        push();
        exmem_rd = 5'd1; exmem_reg_write = 1'b1; exmem_is_load = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_stall", 64'(stall_count), 64'd3);
        clear_fwd();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_stall", 64'(stall_count), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_op_a", op_a, 64'd0);
        #3;
        rst_n = 1'b1;
        rs1_data = 64'h66;
        push();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_op_a", op_a, 64'h66);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
